// File: rtl/spi_memory_slave.sv
// ---------------------------------------------------------------------------
// spi_memory_slave
//
// SPI-attached word memory. A frame starts with chip select low, followed by
// an address frame of addrwidth+1 bits (address MSB-first, then R/W with
// 1 = read). A write then shifts datawidth bits in on SCLK rising edges and
// commits them to memory; a read drives the addressed word out MSB-first on
// SCLK falling edges. Raising chip select at any point abandons the frame.
//
// Ports:
//   clk               system clock, all state lives in this domain
//   reset             asynchronous active-high reset
//   cs_conditioned    debounced chip select, active-low
//   mosi_conditioned  debounced serial data in
//   sclk_posedge      one-clk pulse on a debounced SCLK rising edge
//   sclk_negedge      one-clk pulse on a debounced SCLK falling edge
//   miso              serial data out (registered)
//   miso_enable       tristate enable for the external MISO buffer (registered)
// ---------------------------------------------------------------------------
module spi_memory_slave #(
    parameter int addrwidth = 7,
    parameter int datawidth = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_conditioned,
    input  logic mosi_conditioned,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    output logic miso,
    output logic miso_enable
);

    localparam int DEPTH = 2 ** addrwidth;
    // The shift register must hold the whole address frame as well as a word.
    localparam int SW    = ((addrwidth + 1) > datawidth) ? (addrwidth + 1) : datawidth;
    localparam int CNTW  = $clog2(SW + 1);

    localparam logic [CNTW-1:0] C_ALAST = CNTW'(addrwidth);
    localparam logic [CNTW-1:0] C_DLAST = CNTW'(datawidth - 1);
    localparam logic [CNTW-1:0] C_DW    = CNTW'(datawidth);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        GET_ADDR     = 3'd1,
        READ_LOAD    = 3'd2,
        READ         = 3'd3,
        WRITE        = 3'd4,
        WRITE_COMMIT = 3'd5,
        DONE         = 3'd6
    } state_t;

    state_t                 r_state;
    logic [CNTW-1:0]        r_cnt;
    logic [SW-1:0]          r_shift;
    logic [addrwidth-1:0]   r_addr;
    logic                   r_rw;
    logic                   r_miso;
    logic                   r_miso_en;
    logic [datawidth-1:0]   r_rd_data;
    logic [datawidth-1:0]   r_mem [0:DEPTH-1];

    state_t                 w_state_next;
    logic [CNTW-1:0]        w_cnt_next;
    logic [SW-1:0]          w_shift_next;
    logic [addrwidth-1:0]   w_addr_next;
    logic                   w_rw_next;
    logic                   w_miso_next;
    logic                   w_miso_en_next;
    logic                   w_mem_we;
    logic                   w_pos;
    logic                   w_neg;

    // A rising edge wins when both pulses land in the same clk.
    assign w_pos = sclk_posedge;
    assign w_neg = sclk_negedge & ~sclk_posedge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_en <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_addr    <= w_addr_next;
            r_rw      <= w_rw_next;
            r_miso    <= w_miso_next;
            r_miso_en <= w_miso_en_next;
        end
    end

    // Memory is never reset. The read port is addressed with the address
    // being latched this cycle, so the word is ready when READ_LOAD runs.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_shift[datawidth-1:0];
        end
        r_rd_data <= r_mem[w_addr_next];
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_shift_next   = r_shift;
        w_addr_next    = r_addr;
        w_rw_next      = r_rw;
        w_miso_next    = r_miso;
        w_miso_en_next = r_miso_en;
        w_mem_we       = 1'b0;

        if (r_state != IDLE && cs_conditioned) begin
            // Chip select released: abandon whatever is in flight.
            w_state_next   = IDLE;
            w_cnt_next     = '0;
            w_miso_next    = 1'b0;
            w_miso_en_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_miso_en_next = 1'b0;
                    if (!cs_conditioned) begin
                        w_state_next = GET_ADDR;
                        w_cnt_next   = '0;
                    end
                end
                GET_ADDR: begin
                    if (w_pos) begin
                        w_shift_next = {r_shift[SW-2:0], mosi_conditioned};
                        w_cnt_next   = r_cnt + 1'b1;
                        if (r_cnt == C_ALAST) begin
                            // Bits already held are the address; this one is R/W.
                            w_addr_next  = r_shift[addrwidth-1:0];
                            w_rw_next    = mosi_conditioned;
                            w_cnt_next   = '0;
                            w_state_next = mosi_conditioned ? READ_LOAD : WRITE;
                        end
                    end
                end
                READ_LOAD: begin
                    w_shift_next                  = '0;
                    w_shift_next[datawidth-1:0]   = r_rd_data;
                    w_miso_en_next                = 1'b1;
                    w_state_next                  = READ;
                end
                READ: begin
                    if (w_pos) begin
                        if (r_cnt == C_DW) begin
                            w_state_next   = DONE;
                            w_miso_en_next = 1'b0;
                        end
                    end else if (w_neg && r_cnt != C_DW) begin
                        w_miso_next  = r_shift[datawidth-1];
                        w_shift_next = r_shift << 1;
                        w_cnt_next   = r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (w_pos) begin
                        w_shift_next = {r_shift[SW-2:0], mosi_conditioned};
                        w_cnt_next   = r_cnt + 1'b1;
                        if (r_cnt == C_DLAST) begin
                            w_cnt_next   = '0;
                            w_state_next = WRITE_COMMIT;
                        end
                    end
                end
                WRITE_COMMIT: begin
                    w_mem_we     = ~r_rw;
                    w_state_next = DONE;
                end
                DONE: begin
                    w_miso_en_next = 1'b0;
                end
                default: begin
                    w_state_next   = IDLE;
                    w_miso_en_next = 1'b0;
                end
            endcase
        end
    end

    assign miso        = r_miso;
    assign miso_enable = r_miso_en;

endmodule

// File: tb/tb_spi_memory_slave.sv
module tb_spi_memory_slave;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_conditioned = 1'b1;
    logic mosi_conditioned = 1'b0;
    logic sclk_posedge = 1'b0;
    logic sclk_negedge = 1'b0;
    logic miso;
    logic miso_enable;

    int n_vec = 0;
    int n_err = 0;

    spi_memory_slave #(.addrwidth(7), .datawidth(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .cs_conditioned   (cs_conditioned),
        .mosi_conditioned (mosi_conditioned),
        .sclk_posedge     (sclk_posedge),
        .sclk_negedge     (sclk_negedge),
        .miso             (miso),
        .miso_enable      (miso_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SCLK rising edge (optionally coincident with a falling-edge pulse),
    // followed by an idle clk to respect the minimum edge spacing.
    task automatic rise(input logic b, input logic both);
        mosi_conditioned = b;
        sclk_posedge     = 1'b1;
        sclk_negedge     = both;
        tick();
        sclk_posedge     = 1'b0;
        sclk_negedge     = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        cs_conditioned = 1'b1;
        tick();
        tick();
    endtask

    // nbits < 8 raises chip select after that many data bits.
    task automatic write_frame(input logic [6:0] addr, input logic [7:0] data,
                               input int nbits, input bit chk_prev, input logic [7:0] prev);
        cs_conditioned = 1'b0;
        tick();
        for (int i = 6; i >= 0; i--) rise(addr[i], 1'b0);
        rise(1'b0, 1'b0);
        for (int i = 7; i >= 8 - nbits + 1; i--) rise(data[i], 1'b0);
        if (nbits < 8) begin
            rise(data[8 - nbits], 1'b0);
            cs_conditioned = 1'b1;
            tick();
            check("abort_state_idle", 32'(dut.r_state), 32'd0);
            check("abort_en", 32'(miso_enable), 32'd0);
            tick();
            return;
        end
        mosi_conditioned = data[0];
        sclk_posedge     = 1'b1;
        tick();
        sclk_posedge     = 1'b0;
        if (chk_prev) check("wr_not_early", 32'(dut.r_mem[addr]), 32'(prev));
        check("wr_en_low", 32'(miso_enable), 32'd0);
        tick();
        check("wr_mem", 32'(dut.r_mem[addr]), 32'(data));
        check("wr_en_low2", 32'(miso_enable), 32'd0);
        end_frame();
    endtask

    // both_idx: address bit index sent with coincident edge pulses (-1 none).
    // rst_after: async reset pulsed after this many data bits (-1 none).
    task automatic read_frame(input logic [6:0] addr, input logic [7:0] exp,
                              input int both_idx, input int rst_after);
        cs_conditioned = 1'b0;
        tick();
        for (int i = 6; i >= 0; i--) rise(addr[i], (i == both_idx));
        mosi_conditioned = 1'b1;
        sclk_posedge     = 1'b1;
        tick();
        sclk_posedge     = 1'b0;
        check("rd_en_pre", 32'(miso_enable), 32'd0);
        tick();
        check("rd_en_rise", 32'(miso_enable), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            sclk_negedge = 1'b1;
            tick();
            sclk_negedge = 1'b0;
            check($sformatf("rd_bit%0d", i), 32'(miso), 32'(exp[i]));
            if (rst_after == 8 - i) begin
                #2 reset = 1'b1;
                #1;
                check("rst_miso", 32'(miso), 32'd0);
                check("rst_en", 32'(miso_enable), 32'd0);
                #2 reset = 1'b0;
                cs_conditioned = 1'b1;
                tick();
                tick();
                return;
            end
            tick();
            rise(1'b0, 1'b0);
        end
        check("rd_en_done", 32'(miso_enable), 32'd0);
        end_frame();
    endtask

    initial begin
        #2;
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_en", 32'(miso_enable), 32'd0);
        check("reset_state", 32'(dut.r_state), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("idle_hold", 32'(dut.r_state), 32'd0);

        write_frame(7'h15, 8'hA5, 8, 1'b0, 8'h00);
        read_frame(7'h15, 8'hA5, -1, -1);

        write_frame(7'h03, 8'h3C, 8, 1'b0, 8'h00);
        write_frame(7'h03, 8'hC3, 4, 1'b0, 8'h00);
        check("abort_mem", 32'(dut.r_mem[7'h03]), 32'h3C);
        read_frame(7'h03, 8'h3C, -1, -1);

        read_frame(7'h15, 8'hA5, -1, 3);
        read_frame(7'h15, 8'hA5, -1, -1);

        write_frame(7'h7F, 8'hFF, 8, 1'b0, 8'h00);
        write_frame(7'h00, 8'h00, 8, 1'b0, 8'h00);
        read_frame(7'h7F, 8'hFF, -1, -1);
        read_frame(7'h00, 8'h00, -1, -1);

        write_frame(7'h15, 8'h5A, 8, 1'b1, 8'hA5);
        read_frame(7'h15, 8'h5A, 2, -1);
        read_frame(7'h7F, 8'hFF, 5, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
